pipelined_barrel_shifter: RTL and testbench
===========================================

Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined successor to the 4-bit rotate block.
- Shifts or rotates a WIDTH-bit word by 0..WIDTH-1 positions:
  - left or right direction;
  - rotate, logical or arithmetic kind.
- Uses log2(WIDTH) registered stages and a valid/ready handshake on both sides.
- Sits between a producer datapath and a consumer that may stall.

Parameters:
- WIDTH, 8, data width; power of two, >= 4.
- TAG_W, 4, width of a sideband tag carried alongside the data; >= 1.
- SW (localparam), $clog2(WIDTH), shift-amount width and number of pipeline stages.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  WIDTH  operand.
- in_amt  in  SW  shift amount.
- in_dir  in  1  0 = left, 1 = right.
- in_kind  in  2  00 rotate, 01 logical, 10 arithmetic, 11 reserved (behaves as logical).
- in_tag  in  TAG_W  opaque sideband; returned unchanged with the result.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  shifted or rotated result.
- out_tag  out  TAG_W  tag of the beat that produced out_data.

Behaviour:
- Pipeline structure:
  - SW stages; stage k (k = 0..SW-1) applies a shift/rotate of 2^k positions when amt[k] = 1, otherwise passes through.
  - Each stage register holds: valid, data, amt, dir, kind, tag.
- Advance rule:
  - advance = !out_valid || out_ready.
  - When advance = 1, every stage loads from its predecessor, and stage 0 loads from the inputs.
  - When advance = 0, all stages hold.
  - in_ready = advance (combinational from out_valid and out_ready only; never depends on in_valid).
- Transfer rules:
  - An input beat is accepted when in_valid && in_ready.
  - If in_valid = 0 while advancing, a bubble (valid = 0) enters stage 0.
  - An output is consumed when out_valid && out_ready.
- Timing:
  - Latency is exactly SW cycles from acceptance to out_valid with no stalls.
  - Throughput is 1 beat/cycle.
  - Order is preserved; bubbles propagate unchanged.
- Stall behaviour:
  - While out_valid && !out_ready, out_data and out_tag are held stable.
  - No beat is lost or duplicated.
  - Bubbles are not squeezed out during stalls (simple global stall).
- Arithmetic rules (amt = full SW-bit value):
  - Rotate left: out = (d << amt) | (d >> (WIDTH - amt)); amt = 0 returns d.
  - Rotate right: mirror of rotate left.
  - Logical left/right: vacated bits are 0.
  - Arithmetic right: vacated bits equal d[WIDTH-1].
  - Arithmetic left: identical to logical left.
  - Kind 11: identical to logical.
  - amt = 0: out_data = in_data for every mode.
  - amt = WIDTH-1 is the maximum; there is no out-of-range amount.
- Reset:
  - Asynchronous assertion clears all stage valid bits.
  - out_valid = 0, out_data = 0, out_tag = 0 at reset; all data and sideband registers are also reset to 0.
  - in_ready = 1 immediately after reset.
  - Reset mid-operation discards all in-flight beats; none emerge after release.
  - Deassertion is assumed synchronised upstream; the first beat may be accepted on the first edge after release.

Decomposition:
- Shared package pbs_pkg:
  - kind encodings KIND_ROT = 2'b00, KIND_LOG = 2'b01, KIND_ARI = 2'b10;
  - DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1.
- One sub-module pbs_stage, parameterised by WIDTH, TAG_W, SW and STEP (= 2^k):
  - combinational conditional shift by STEP, followed by the stage register with hold enable;
  - the top level instantiates SW copies in a generate loop and owns the advance/ready logic.

Test Plan:
- Directed cases, all with WIDTH = 8 (latency = 3 cycles):
  - Rotate left, d = 8'b1001_0110, amt = 3, tag = 5, out_ready = 1 → exactly 3 cycles later: out_valid = 1, out_data = 8'b1011_0100, out_tag = 5.
  - Arithmetic right, d = 8'hA4, amt = 2 → 8'hE9. Same d with logical right → 8'h29. Rotate right → 8'h29. Logical left, amt = 7 → 8'h00.
  - Back-to-back: 8 beats with amt = 0..7, rotate left of 8'h01 on consecutive cycles → outputs 8'h01, 02, 04 … 80 on 8 consecutive cycles in order, tags matching.
  - Backpressure: stream 6 beats, drop out_ready for 4 cycles once out_valid rises:
    - in_ready = 0 during the stall;
    - out_data stable during the stall;
    - all 6 results delivered in order with no loss or duplicates.
  - Reset mid-stream: assert rst_n = 0 asynchronously with 3 beats in flight → out_valid = 0 and out_data = 0 immediately; after release, no stale beat emerges and in_ready = 1.
  - Randomised mode/amt/data sweep against a reference model, with random in_valid/out_ready → every result and tag matches, in order.

Source files
------------

// File: rtl/pbs_pkg.sv
// Shared encodings for the pipelined barrel shifter: shift kinds and directions.
package pbs_pkg;

  localparam logic [1:0] KIND_ROT = 2'b00;
  localparam logic [1:0] KIND_LOG = 2'b01;
  localparam logic [1:0] KIND_ARI = 2'b10;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/pbs_stage.sv
// One pipeline stage: conditionally shifts/rotates by STEP positions, then
// registers the result together with the rest of the beat under a hold enable.
module pbs_stage
  import pbs_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4,
  parameter int SW    = 3,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SW-1:0]    amt_i,
  input  logic             dir_i,
  input  logic [1:0]       kind_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [SW-1:0]    amt_o,
  output logic             dir_o,
  output logic [1:0]       kind_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int BIT = $clog2(STEP);

  logic [WIDTH-1:0] shifted;

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d,  data_q;
  logic [SW-1:0]    amt_d,   amt_q;
  logic             dir_d,   dir_q;
  logic [1:0]       kind_d,  kind_q;
  logic [TAG_W-1:0] tag_d,   tag_q;

  // Reserved kind 2'b11 falls into the default (logical) arm in both directions.
  always_comb begin
    shifted = data_i;
    if (amt_i[BIT]) begin
      if (dir_i == DIR_LEFT) begin
        if (kind_i == KIND_ROT) shifted = (data_i << STEP) | (data_i >> (WIDTH - STEP));
        else                    shifted = data_i << STEP;
      end else begin
        case (kind_i)
          KIND_ROT: shifted = (data_i >> STEP) | (data_i << (WIDTH - STEP));
          KIND_ARI: shifted = WIDTH'($signed(data_i) >>> STEP);
          default:  shifted = data_i >> STEP;
        endcase
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    amt_d   = amt_q;
    dir_d   = dir_q;
    kind_d  = kind_q;
    tag_d   = tag_q;
    if (en) begin
      valid_d = valid_i;
      data_d  = shifted;
      amt_d   = amt_i;
      dir_d   = dir_i;
      kind_d  = kind_i;
      tag_d   = tag_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      dir_q   <= 1'b0;
      kind_q  <= 2'b00;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      dir_q   <= dir_d;
      kind_q  <= kind_d;
      tag_q   <= tag_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign amt_o   = amt_q;
  assign dir_o   = dir_q;
  assign kind_o  = kind_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined WIDTH-bit shifter/rotator: SW stages of power-of-two steps with a
// single global stall driven by the output handshake.
module pipelined_barrel_shifter
  import pbs_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int TAG_W = 4,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_amt,
  input  logic             in_dir,
  input  logic [1:0]       in_kind,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  // Handshake: a beat moves on a side when valid && ready that cycle. The whole
  // pipe advances when the output slot is empty or being drained, so in_ready
  // depends only on out_valid/out_ready and never on in_valid.
  logic advance;

  logic [SW:0]                 v_c;
  logic [SW:0][WIDTH-1:0]      d_c;
  logic [SW:0][SW-1:0]         a_c;
  logic [SW:0]                 dir_c;
  logic [SW:0][1:0]            k_c;
  logic [SW:0][TAG_W-1:0]      t_c;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign v_c[0]   = in_valid;
  assign d_c[0]   = in_data;
  assign a_c[0]   = in_amt;
  assign dir_c[0] = in_dir;
  assign k_c[0]   = in_kind;
  assign t_c[0]   = in_tag;

  for (genvar k = 0; k < SW; k++) begin : g_stage
    pbs_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .SW    (SW),
      .STEP  (1 << k)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (advance),
      .valid_i (v_c[k]),
      .data_i  (d_c[k]),
      .amt_i   (a_c[k]),
      .dir_i   (dir_c[k]),
      .kind_i  (k_c[k]),
      .tag_i   (t_c[k]),
      .valid_o (v_c[k+1]),
      .data_o  (d_c[k+1]),
      .amt_o   (a_c[k+1]),
      .dir_o   (dir_c[k+1]),
      .kind_o  (k_c[k+1]),
      .tag_o   (t_c[k+1])
    );
  end

  assign out_valid = v_c[SW];
  assign out_data  = d_c[SW];
  assign out_tag   = t_c[SW];

  // Control fields of the last stage have no consumer beyond the pipe.
  logic unused_tail;
  assign unused_tail = ^{a_c[SW], dir_c[SW], k_c[SW]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: directed cases plus a randomised sweep
// scored against a behavioural shift model.
module tb_pipelined_barrel_shifter;
  import pbs_pkg::*;

  localparam int W     = 8;
  localparam int TAG_W = 4;
  localparam int SW    = $clog2(W);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic [SW-1:0]    in_amt;
  logic             in_dir;
  logic [1:0]       in_kind;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [TAG_W-1:0] out_tag;

  pipelined_barrel_shifter #(.WIDTH(W), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_dir    (in_dir),
    .in_kind   (in_kind),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input int amt,
                                         input logic dr, input logic [1:0] k);
    logic [2*W-1:0] ext;
    if (k == KIND_ROT) begin
      ext = {d, d};
      if (dr == DIR_LEFT) begin
        ext = ext << amt;
        return ext[2*W-1:W];
      end
      ext = ext >> amt;
      return ext[W-1:0];
    end
    if (dr == DIR_LEFT) return d << amt;
    if (k == KIND_ARI) begin
      ext = {{W{d[W-1]}}, d};
      ext = ext >> amt;
      return ext[W-1:0];
    end
    return d >> amt;
  endfunction

  // ---------------- scoreboard ----------------
  logic [TAG_W+W-1:0] exp_q[$];
  logic [W-1:0]       log_d[$];
  logic [TAG_W-1:0]   log_t[$];
  int                 log_c[$];

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got tag %0h data %0h with nothing outstanding", out_tag, out_data);
        end else begin
          chk("out_beat", 64'({out_tag, out_data}), 64'(exp_q[0]));
          if (out_ready) begin
            log_d.push_back(out_data);
            log_t.push_back(out_tag);
            log_c.push_back(cyc);
            void'(exp_q.pop_front());
          end
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back({in_tag, model(in_data, int'(in_amt), in_dir, in_kind)});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] d, input logic [SW-1:0] a, input logic dr,
                      input logic [1:0] k, input logic [TAG_W-1:0] t);
    logic ok;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_dir   = dr;
    in_kind  = k;
    in_tag   = t;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    chk("send_accepted", 64'(ok), 64'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic directed_one(input string name, input logic [W-1:0] d, input logic [SW-1:0] a,
                              input logic dr, input logic [1:0] k, input logic [TAG_W-1:0] t,
                              input logic [W-1:0] exp);
    send(d, a, dr, k, t);
    in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_lat0"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    chk({name, "_lat1"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_data"}, 64'(out_data), 64'(exp));
    chk({name, "_tag"}, 64'(out_tag), 64'(t));
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] bp_d[6];
  logic [SW-1:0] bp_a[6];
  logic [W-1:0] bp_exp[6];
  logic [W-1:0] one;
  logic         rnd_done;
  int           base;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0;
    in_dir = 1'b0; in_kind = 2'b00; in_tag = '0; out_ready = 1'b1;
    rnd_done = 1'b0;

    #3;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data", 64'(out_data), 64'd0);
    chk("reset_out_tag", 64'(out_tag), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;

    // Pin the model with hand-computed values.
    chk("model_rotl", 64'(model(8'b1001_0110, 3, DIR_LEFT, KIND_ROT)), 64'h B4);
    chk("model_arir", 64'(model(8'hA4, 2, DIR_RIGHT, KIND_ARI)), 64'h E9);
    chk("model_logr", 64'(model(8'hA4, 2, DIR_RIGHT, KIND_LOG)), 64'h 29);
    chk("model_rotr", 64'(model(8'hA4, 2, DIR_RIGHT, KIND_ROT)), 64'h 29);
    chk("model_logl7", 64'(model(8'hA4, 7, DIR_LEFT, KIND_LOG)), 64'h 00);
    chk("model_res_r", 64'(model(8'h80, 1, DIR_RIGHT, 2'b11)), 64'h 40);

    // Directed single beats with exact latency.
    directed_one("rotl", 8'b1001_0110, 3'd3, DIR_LEFT, KIND_ROT, 4'd5, 8'b1011_0100);
    directed_one("arir", 8'hA4, 3'd2, DIR_RIGHT, KIND_ARI, 4'd1, 8'hE9);
    directed_one("logr", 8'hA4, 3'd2, DIR_RIGHT, KIND_LOG, 4'd2, 8'h29);
    directed_one("rotr", 8'hA4, 3'd2, DIR_RIGHT, KIND_ROT, 4'd3, 8'h29);
    directed_one("logl7", 8'hA4, 3'd7, DIR_LEFT, KIND_LOG, 4'd4, 8'h00);
    directed_one("aril", 8'hC3, 3'd1, DIR_LEFT, KIND_ARI, 4'd6, 8'h86);
    directed_one("resr", 8'h80, 3'd1, DIR_RIGHT, 2'b11, 4'd7, 8'h40);
    directed_one("amt0", 8'h5A, 3'd0, DIR_RIGHT, KIND_ARI, 4'd8, 8'h5A);

    // Back-to-back rotate-left of 1 by 0..7.
    base = log_d.size();
    for (int i = 0; i < 8; i++) send(8'h01, SW'(i), DIR_LEFT, KIND_ROT, TAG_W'(i));
    idle(1);
    drain();
    chk("b2b_count", 64'(log_d.size() - base), 64'd8);
    if (log_d.size() - base == 8) begin
      for (int i = 0; i < 8; i++) begin
        one = 8'h01;
        chk("b2b_data", 64'(log_d[base+i]), 64'(one << i));
        chk("b2b_tag", 64'(log_t[base+i]), 64'(i));
        chk("b2b_cycle", 64'(log_c[base+i]), 64'(log_c[base] + i));
      end
    end

    // Backpressure: stall 4 cycles after the first result appears.
    for (int i = 0; i < 6; i++) begin
      bp_d[i]   = W'($urandom);
      bp_a[i]   = SW'($urandom_range(0, W - 1));
      bp_exp[i] = model(bp_d[i], int'(bp_a[i]), DIR_LEFT, KIND_ROT);
    end
    base = log_d.size();
    fork
      begin
        for (int i = 0; i < 6; i++) send(bp_d[i], bp_a[i], DIR_LEFT, KIND_ROT, TAG_W'(8 + i));
        in_valid = 1'b0;
      end
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!out_valid && n < 50);
        chk("bp_first_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("bp_in_ready_low", 64'(in_ready), 64'd0);
          chk("bp_hold_valid", 64'(out_valid), 64'd1);
          chk("bp_hold_data", 64'(out_data), 64'(bp_exp[1]));
          chk("bp_hold_tag", 64'(out_tag), 64'd9);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", 64'(log_d.size() - base), 64'd6);
    if (log_d.size() - base == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk("bp_order_data", 64'(log_d[base+i]), 64'(bp_exp[i]));
        chk("bp_order_tag", 64'(log_t[base+i]), 64'(8 + i));
      end
    end

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) send(8'hFF, SW'(i), DIR_LEFT, KIND_ROT, TAG_W'(i + 1));
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_data", 64'(out_data), 64'd0);
    chk("rst_mid_tag", 64'(out_tag), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_in_ready", 64'(in_ready), 64'd1);
    repeat (6) begin
      @(negedge clk);
      chk("rst_no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;

    // Randomised sweep with random gaps and consumer stalls.
    base = log_d.size();
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(W'($urandom), SW'($urandom_range(0, W - 1)), 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), TAG_W'($urandom));
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("rand_count", 64'(log_d.size() - base), 64'd300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
